// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: bus bundle for reg_file_mp.
// Carries the write port, the packed functional read ports, the debug read
// port and the init sequencer handshake. The slave modport is the register
// file's view; the master modport is the datapath/driver view.
interface reg_file_mp_if #(
   parameter int DW     = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2
);
   localparam int AW = $clog2(DEPTH);

   logic                   init_req;
   logic                   init_busy;
   logic                   we;
   logic [AW-1:0]          waddr;
   logic [DW-1:0]          wdata;
   logic                   wr_drop;
   logic [NUM_RD*AW-1:0]   raddr;
   logic [NUM_RD*DW-1:0]   rdata;
   logic [AW-1:0]          raddr_debug;
   logic [DW-1:0]          rdata_debug;

   modport slave (
      input  init_req, we, waddr, wdata, raddr, raddr_debug,
      output init_busy, wr_drop, rdata, rdata_debug
   );

   modport master (
      output init_req, we, waddr, wdata, raddr, raddr_debug,
      input  init_busy, wr_drop, rdata, rdata_debug
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file.
// - One write port, NUM_RD functional read ports and one debug read port,
//   all reads registered (latency 1) with write-first bypass.
// - Init sequencer loads entry i with value i, one entry per cycle, after
//   reset or an init_req pulse; reads return 0 and writes are dropped while
//   it runs.
// - Optional: define REGFILE_R0_ZERO_EN to hardwire entry 0 to zero.
module reg_file_mp #(
   parameter int DW     = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2
) (
   input logic          CLOCK,
   input logic          reset,
   reg_file_mp_if.slave bus
);
   localparam int              AW      = $clog2(DEPTH);
   localparam logic [AW:0]     DEPTH_X = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]   LAST    = AW'(DEPTH-1);
`ifdef REGFILE_R0_ZERO_EN
   localparam bit              R0_EN   = 1'b1;
`else
   localparam bit              R0_EN   = 1'b0;
`endif

   typedef enum logic {IDLE, INIT} state_t;

   state_t               state, state_nx;
   logic [AW-1:0]        cnt, cnt_nx;
   logic [DW-1:0]        mem [DEPTH];

   logic                 wr_ok;
   logic                 wr_eff;
   logic                 drop_q;
   logic                 mem_we;
   logic [AW-1:0]        mem_wa;
   logic [DW-1:0]        mem_wd;
   logic [NUM_RD*DW-1:0] rd_nx, rdata_q;
   logic [DW-1:0]        dbg_nx, dbg_q;

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_X;
   endfunction

   // Zero/forced cases win over bypass, so address 0 never bypasses when
   // entry 0 is hardwired.
   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      if (state == INIT || !in_range(a) || (R0_EN && a == '0))
         return '0;
      else if (wr_ok && a == bus.waddr)
         return bus.wdata;
      else
         return mem[a];
   endfunction

   // Write acceptance: only in IDLE and only to an existing entry.
   always_comb begin
      wr_ok  = (state == IDLE) && bus.we && in_range(bus.waddr);
      wr_eff = wr_ok && !(R0_EN && bus.waddr == '0);
   end

   // FSM next state and init counter.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.init_req) begin
               state_nx = INIT;
               cnt_nx   = '0;
            end
         end
         INIT: begin
            if (cnt == LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
      endcase
   end

   // FSM state register and write-drop flag.
   always_ff @(posedge CLOCK) begin
      if (!reset) begin
         state  <= INIT;
         cnt    <= '0;
         drop_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         drop_q <= bus.we && !wr_ok;
      end
   end

   // Single array write port shared by the sequencer and the functional write.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = bus.waddr;
      mem_wd = bus.wdata;
      if (state == INIT) begin
         mem_we = 1'b1;
         mem_wa = cnt;
         mem_wd = DW'(cnt);
      end else if (wr_eff) begin
         mem_we = 1'b1;
      end
   end

   // Array update; reset leaves contents untouched.
   always_ff @(posedge CLOCK) begin
      if (reset && mem_we)
         mem[mem_wa] <= mem_wd;
   end

   // Next read data for every functional port and the debug port.
   always_comb begin
      rd_nx = '0;
      for (int unsigned k = 0; k < NUM_RD; k++)
         rd_nx[k*DW +: DW] = rd_val(bus.raddr[k*AW +: AW]);
      dbg_nx = rd_val(bus.raddr_debug);
   end

   // Registered read outputs.
   always_ff @(posedge CLOCK) begin
      if (!reset) begin
         rdata_q <= '0;
         dbg_q   <= '0;
      end else begin
         rdata_q <= rd_nx;
         dbg_q   <= dbg_nx;
      end
   end

   assign bus.init_busy   = (state == INIT);
   assign bus.wr_drop     = drop_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_debug = dbg_q;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the team's 32x32 register file.
- Configurable data width, depth and number of read ports, plus a debug read port.
- Adds write-to-read bypass and an on-chip initialisation sequencer that loads entry i with value i, one entry per cycle, so the array stays RAM-inferable.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port); the debug port feeds the board display logic.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of entries (>=2, need not be a power of 2).
- NUM_RD, 2, number of functional read ports (1..4).
- AW, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- CLOCK  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low.
- init_req  in  1  one-cycle pulse; restarts the init sequence from IDLE.
- init_busy  out  1  high while the init sequence runs.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- wr_drop  out  1  registered pulse: a write with we=1 was discarded.
- raddr  in  NUM_RD*AW  packed read addresses; port k = bits [k*AW +: AW].
- rdata  out  NUM_RD*DW  packed read data, registered.
- raddr_debug  in  AW  debug read address.
- rdata_debug  out  DW  debug read data, registered.

Behaviour:
- Reset (reset=0 at posedge):
  - state=INIT, cnt=0, init_busy=1, wr_drop=0.
  - All rdata and rdata_debug cleared to 0.
  - Array contents untouched; we and init_req are ignored.
- State machine has two states, IDLE and INIT:
  - INIT: each cycle write array[cnt] = cnt, zero-extended or truncated to DW, then cnt++.
  - INIT ends at cnt==DEPTH-1; the next state is IDLE, and init_busy=0 from the following cycle.
  - Init therefore takes exactly DEPTH cycles after reset is released.
  - IDLE: init_req=1 -> INIT with cnt=0, init_busy=1 on the next cycle.
  - init_req during INIT is ignored; the sequence does not restart.
- Writes:
  - In IDLE, with we=1 and waddr<DEPTH: array[waddr] <= wdata at posedge.
  - we=1 during INIT, or with waddr>=DEPTH: write discarded, wr_drop=1 the next cycle.
  - Otherwise wr_drop=0.
- Reads:
  - Latency 1: rdata port k at cycle n+1 reflects raddr port k at cycle n.
  - Bypass (write-first): if port k's address equals waddr, we=1 and the write is accepted in the same cycle, rdata k = wdata, not old contents. The debug port obeys the same rule.
  - raddr>=DEPTH -> rdata 0.
  - During INIT, all read outputs (including debug) are forced to 0.
  - Any number of ports may read the same address in the same cycle.
- Reset mid-init: the sequence restarts at cnt=0 and runs the full DEPTH cycles.
- No negedge logic; single clock domain.

Optional Feature:
- Macro REGFILE_R0_ZERO_EN.
- When defined:
  - Entry 0 is hardwired to zero: writes to address 0 are accepted silently (no wr_drop) but have no effect.
  - Reads of address 0 return 0, and bypass never applies to address 0.
  - The init sequencer still writes 0 to entry 0.
- When undefined: entry 0 behaves like every other entry.

Test Plan (DW=32, DEPTH=32, NUM_RD=2):
- Hold reset=0 for 3 cycles, then release -> init_busy=1 for exactly 32 cycles then 0; afterwards raddr0=5, raddr1=31 -> rdata0=5, rdata1=31 next cycle.
- In IDLE, we=1 waddr=7 wdata=0xDEADBEEF, with raddr0=7 in the same cycle -> rdata0=0xDEADBEEF next cycle (bypass). Later read of 7 also returns 0xDEADBEEF.
- we=1 waddr=3 during INIT -> wr_drop=1 one cycle later; after init, read 3 -> 3.
- init_req pulse after overwriting entry 10 with 0x55 -> init_busy reasserts for 32 cycles; read 10 afterwards -> 10. A second init_req mid-sequence does not lengthen it.
- Assert reset=0 at cnt=12 of init -> rdata=0, init_busy stays 1; the full 32-cycle init runs after release.
- With REGFILE_R0_ZERO_EN defined: write 0x1234 to address 0 -> wr_drop=0, read 0 returns 0. Without the macro, the same read returns 0x1234.
